// File: rtl/pixel_write_queue_pkg.sv
// Shared screen geometry and colour constants for the board painter pipeline.
package pixel_write_queue_pkg;

  localparam int SCR_WIDTH_BITS  = 8;
  localparam int SCR_HEIGHT_BITS = 7;
  localparam int COLOR_SIZE      = 3;
  localparam int SCR_WIDTH       = 160;
  localparam int SCR_HEIGHT      = 120;
  localparam int QUEUE_DEPTH     = 8;

  localparam logic [COLOR_SIZE-1:0] BG_COLOR = 3'b000;

endpackage

// File: rtl/pixel_write_queue_fifo.sv
// Small synchronous FIFO holding packed {x, y, colour} pixel requests.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module pixel_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/pixel_write_queue.sv
// Turns the painter's level print_enable into one plot strobe per rising edge,
// buffering requests in a FIFO, and sweeps the screen to the background colour
// after reset or on clear_req before draining the queue.
//
//   state | meaning
//   CLEAR | sweeping cx/cy over the whole screen, one pixel per cycle
//   RUN   | popping queued pixels onto the framebuffer outputs
module pixel_write_queue
  import pixel_write_queue_pkg::*;
#(
  parameter int X_BITS     = SCR_WIDTH_BITS,
  parameter int Y_BITS     = SCR_HEIGHT_BITS,
  parameter int COLOR_BITS = COLOR_SIZE,
  parameter int SCR_W      = SCR_WIDTH,
  parameter int SCR_H      = SCR_HEIGHT,
  parameter int DEPTH      = QUEUE_DEPTH,
  parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = BG_COLOR
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic [X_BITS-1:0]     in_x,
  input  logic [Y_BITS-1:0]     in_y,
  input  logic [COLOR_BITS-1:0] in_color,
  input  logic                  in_enable,
  input  logic                  clear_req,
  output logic [X_BITS-1:0]     out_x,
  output logic [Y_BITS-1:0]     out_y,
  output logic [COLOR_BITS-1:0] out_color,
  output logic                  out_plot,
  output logic                  clearing,
  output logic                  busy,
  output logic                  overflow
);

  localparam int W  = X_BITS + Y_BITS + COLOR_BITS;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(SCR_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(SCR_H - 1);

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic              en_d;
  logic [X_BITS-1:0] cx;
  logic [Y_BITS-1:0] cy;
  logic              push;
  logic              push_ok;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [W-1:0]      head;
  logic              sweep_last;

  assign push       = in_enable && !en_d;
  assign pop        = (state == ST_RUN) && !empty && !clear_req;
  assign push_ok    = push && (!full || pop);
  assign count_next = count + CW'(push_ok) - CW'(pop);
  assign sweep_last = (cx == X_LAST) && (cy == Y_LAST);

  pixel_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clck),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .din   ({in_x, in_y, in_color}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Next-state selection; clear_req is only honoured from RUN.
  always_comb begin
    state_next = state;
    if (state == ST_CLEAR) begin
      if (sweep_last) state_next = ST_RUN;
    end else if (clear_req) begin
      state_next = ST_CLEAR;
    end
  end

  // State, sweep counters, edge detector, sticky overflow and output registers.
  always_ff @(posedge Clck) begin
    if (Reset) begin
      state     <= ST_CLEAR;
      en_d      <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      overflow  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_color <= '0;
      out_plot  <= 1'b0;
      clearing  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      en_d     <= in_enable;
      state    <= state_next;
      clearing <= (state_next == ST_CLEAR);
      busy     <= (state_next == ST_CLEAR) || (count_next != '0);
      out_plot <= 1'b0;
      if (push && full && !pop) overflow <= 1'b1;

      if (state == ST_CLEAR) begin
        out_x     <= cx;
        out_y     <= cy;
        out_color <= CLEAR_COLOR;
        out_plot  <= 1'b1;
        if (sweep_last) begin
          cx <= '0;
          cy <= '0;
        end else if (cx == X_LAST) begin
          cx <= '0;
          cy <= cy + Y_BITS'(1);
        end else begin
          cx <= cx + X_BITS'(1);
        end
      end else if (clear_req) begin
        cx <= '0;
        cy <= '0;
      end else if (pop) begin
        {out_x, out_y, out_color} <= head;
        out_plot <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_write_queue.sv
// Self-checking bench for pixel_write_queue: a queue-based reference model
// checked every cycle, a vector table for RUN-mode captures, and hand-written
// sequences for sweep, overflow, clear and mid-sweep reset.
module tb_pixel_write_queue;

  localparam int NPIX = 160 * 120;

  logic       Clck = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] in_x = '0;
  logic [6:0] in_y = '0;
  logic [2:0] in_color = '0;
  logic       in_enable = 1'b0;
  logic       clear_req = 1'b0;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_color;
  logic       out_plot, clearing, busy, overflow;

  int n_checks = 0;
  int n_pass   = 0;

  pixel_write_queue dut (
    .Clck(Clck), .Reset(Reset), .in_x(in_x), .in_y(in_y), .in_color(in_color),
    .in_enable(in_enable), .clear_req(clear_req), .out_x(out_x), .out_y(out_y),
    .out_color(out_color), .out_plot(out_plot), .clearing(clearing), .busy(busy),
    .overflow(overflow)
  );

  always #5 Clck = ~Clck;

  // reference model state
  logic [17:0] m_q[$];
  bit          m_en_d, m_sweeping, m_ovf, m_plot, m_clearing, m_busy;
  int          m_pix;
  logic [17:0] m_out;

  logic [17:0] plog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [17:0] pix(input int x, input int y, input int c);
    logic [7:0] xx; logic [6:0] yy; logic [2:0] cc;
    xx = 8'(x); yy = 7'(y); cc = 3'(c);
    return {xx, yy, cc};
  endfunction

  // Apply inputs for one edge, advance the model by the same edge, compare.
  task automatic step(input bit r, input bit en, input logic [17:0] d, input bit clr);
    bit pushing;
    Reset = r; in_enable = en; {in_x, in_y, in_color} = d; clear_req = clr;
    if (r) begin
      m_q.delete(); m_en_d = 0; m_sweeping = 1; m_pix = 0; m_ovf = 0;
      m_out = '0; m_plot = 0; m_clearing = 0; m_busy = 0;
    end else begin
      pushing = en && !m_en_d;
      m_en_d = en;
      m_plot = 0;
      if (m_sweeping) begin
        m_out  = pix(m_pix % 160, m_pix / 160, 0);
        m_plot = 1;
        if (m_pix == NPIX - 1) m_sweeping = 0;
        else m_pix++;
      end else if (clr) begin
        m_sweeping = 1; m_pix = 0;
      end else if (m_q.size() > 0) begin
        m_out  = m_q.pop_front();
        m_plot = 1;
      end
      if (pushing) begin
        if (m_q.size() < 8) m_q.push_back(d);
        else m_ovf = 1;
      end
      m_clearing = m_sweeping;
      m_busy = m_sweeping || (m_q.size() > 0);
    end
    @(posedge Clck);
    @(negedge Clck);
    check("model", {10'd0, out_plot, out_x, out_y, out_color, clearing, busy, overflow},
          {10'd0, m_plot, m_out, m_clearing, m_busy, m_ovf});
    if (out_plot === 1'b1) plog.push_back({out_x, out_y, out_color});
  endtask

  function automatic int sweep_errors();
    int bad = 0;
    for (int i = 0; i < NPIX; i++)
      if (i >= plog.size() || plog[i] !== pix(i % 160, i / 160, 0)) bad++;
    return bad;
  endfunction

  typedef struct {
    bit          en;
    logic [17:0] d;
    bit          e_plot;
    logic [17:0] e_out;
    bit          e_busy;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [17:0] a;
    logic [17:0] pushed[$];

    vt[0]  = '{1, pix(10, 20, 6), 0, pix(159, 119, 0), 1};
    vt[1]  = '{1, pix(10, 20, 6), 1, pix(10, 20, 6), 0};
    vt[2]  = '{1, pix(10, 20, 6), 0, pix(10, 20, 6), 0};
    vt[3]  = '{1, pix(10, 20, 6), 0, pix(10, 20, 6), 0};
    vt[4]  = '{0, pix(10, 20, 6), 0, pix(10, 20, 6), 0};
    vt[5]  = '{1, pix(1, 2, 1),   0, pix(10, 20, 6), 1};
    vt[6]  = '{0, pix(99, 9, 7),  1, pix(1, 2, 1),   0};
    vt[7]  = '{1, pix(3, 4, 2),   0, pix(1, 2, 1),   1};
    vt[8]  = '{0, pix(0, 0, 0),   1, pix(3, 4, 2),   0};
    vt[9]  = '{1, pix(5, 6, 5),   0, pix(3, 4, 2),   1};
    vt[10] = '{0, pix(5, 6, 5),   1, pix(5, 6, 5),   0};
    vt[11] = '{0, pix(5, 6, 5),   0, pix(5, 6, 5),   0};

    // reset held two cycles, then full sweep
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    check("reset_outputs", {out_plot, out_x, out_y, out_color}, '0);
    check("reset_flags", {clearing, busy, overflow}, 3'b000);
    plog.delete();
    for (int i = 0; i < NPIX; i++) step(0, 0, '0, 0);
    check("sweep_count", plog.size(), NPIX);
    check("sweep_order", sweep_errors(), 0);
    check("sweep_end_clearing", clearing, 1'b0);
    step(0, 0, '0, 0);
    check("run_idle_plot", out_plot, 1'b0);
    check("run_idle_busy", busy, 1'b0);

    // RUN-mode capture table
    for (int i = 0; i < 12; i++) begin
      step(0, vt[i].en, vt[i].d, 0);
      check($sformatf("vec%0d_plot", i), out_plot, vt[i].e_plot);
      check($sformatf("vec%0d_pix", i), {out_x, out_y, out_color}, vt[i].e_out);
      check($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
    end

    // random RUN traffic against the model
    for (int i = 0; i < 1000; i++)
      step(0, 1'($urandom_range(0, 1)), 18'($urandom), 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);

    // clear with a queued entry, 11 more pushes during the sweep, mid-sweep clear_req
    a = pix(42, 17, 5);
    pushed.delete();
    pushed.push_back(a);
    step(0, 1, a, 1);
    check("clr_edge_plot", out_plot, 1'b0);
    check("clr_edge_busy", busy, 1'b1);
    plog.delete();
    for (int i = 0; i < NPIX; i++) begin
      if (i % 2 == 1 && i < 22) begin
        logic [17:0] p;
        p = pix(i, i + 50, i % 8);
        pushed.push_back(p);
        step(0, 1, p, 0);
      end else begin
        step(0, 0, '0, (i == 5000));
      end
    end
    check("clr_sweep_count", plog.size(), NPIX);
    check("clr_sweep_order", sweep_errors(), 0);
    check("overflow_set", overflow, 1'b1);
    plog.delete();
    for (int i = 0; i < 12; i++) step(0, 0, '0, 0);
    check("drain_count", plog.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("drain%0d", i), (i < plog.size()) ? plog[i] : 18'h3ffff, pushed[i]);
    check("drain_busy", busy, 1'b0);
    check("overflow_sticky", overflow, 1'b1);

    // reset mid-sweep with a non-empty FIFO
    step(1, 0, '0, 0);
    for (int i = 0; i < 3000; i++)
      step(0, (i % 2 == 1 && i < 6), pix(7, 7, 7 - i % 8), 0);
    check("pre_reset_busy", busy, 1'b1);
    step(1, 0, '0, 0);
    check("midreset_outputs", {out_plot, out_x, out_y, out_color}, '0);
    check("midreset_flags", {clearing, busy, overflow}, 3'b000);
    plog.delete();
    for (int i = 0; i < NPIX + 5; i++) step(0, 0, '0, 0);
    check("restart_count", plog.size(), NPIX);
    check("restart_order", sweep_errors(), 0);
    check("restart_fifo_empty", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
